spi_dac_scheduler: RTL and testbench
====================================

# spi_dac_scheduler

Sequencer and arbiter in front of `spi_main_x2`. It shares the single SPI DAC link between two requesters: the DDS sample stream and the configuration/command path. Each request becomes exactly one SPI frame: the block formats the 16-bit word, selects the link speed and power state, and drives `load` through a closed-loop handshake on `csb`. Sample frames use latest-wins buffering, so the DAC always receives the newest sample. Configuration frames are lossless.

## Interface
- `SAMPLE_CMD`, 4'h3: command nibble prefixed to sample words.
- `CFG_BURST_MAX`, 4: consecutive config frames allowed while a sample is pending.
- `START_TIMEOUT`, 64: cycles allowed in WAIT_START for `csb` to fall (min 2).
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `sample_valid`  in  1  new DDS sample strobe (single-cycle or held).
- `sample_data`  in  12  DAC sample code.
- `cfg_valid`  in  1  config request; held until `cfg_ready`.
- `cfg_word`  in  16  raw config word, sent verbatim.
- `cfg_ready`  out  1  config word accepted this cycle.
- `pwr_req`  in  2  requested DAC power state.
- `load`  out  1  to `spi_main_x2.load`.
- `parallel_in`  out  16  to `spi_main_x2.parallel_in`.
- `power_state`  out  2  to `spi_main_x2.power_state`.
- `speed_sel`  out  1  to `spi_main_x2.speed_sel`; 1 = fast, 0 = slow.
- `csb`  in  1  from `spi_main_x2`; low while a frame is in flight.
- `busy`  out  1  state is not IDLE.
- `err_timeout`  out  1  sticky; set on start timeout, cleared only by reset.
- `drop_cnt`  out  8  saturating count of overwritten samples.

## Operation
- Sample buffer: one entry plus a `samp_pend` flag.
  - `sample_valid` writes `sample_data` into the buffer and sets `samp_pend`.
  - If `samp_pend` is already set and the entry has not been granted this cycle, the entry is overwritten and `drop_cnt` increments, saturating at 255.
- Config path: one holding register.
  - `cfg_ready` = 1 when the config register is empty; the handshake completes when `cfg_valid && cfg_ready`.
- Arbitration happens in IDLE only.
  - Config wins by default.
  - If `samp_pend` is set and `cfg_streak == CFG_BURST_MAX`, the sample wins.
  - `cfg_streak` increments on each config grant and clears on each sample grant.
- Word formatting, latched at grant and held stable until the next grant:
  - Sample frame: `parallel_in = {SAMPLE_CMD, sample}`, `speed_sel` = 1.
  - Config frame: `parallel_in = cfg_word`, `speed_sel` = 0.
  - `power_state` = `pwr_req` sampled at grant.
- FSM states:
  - IDLE: on a grant, latch the word and clear the granted source (`samp_pend` or the config register), then go to LOAD.
  - LOAD: `load` = 1, timer cleared; go to WAIT_START.
  - WAIT_START: `load` stays 1.
    - When `csb` = 0, go to WAIT_DONE with `load` = 0 that cycle.
    - If the timer reaches `START_TIMEOUT` first, set `err_timeout`, drop `load`, and return to IDLE. The frame is lost and not retried.
  - WAIT_DONE: `load` = 0; when `csb` = 1, go to IDLE.
- `drop_cnt` and the sample write logic operate in every state.

## Timing
- Reset values while `rst_n` = 0 at an edge:
  - State IDLE, `load` 0, `parallel_in` 0, `power_state` 2'b11, `speed_sel` 0.
  - `busy` 0, `err_timeout` 0, `drop_cnt` 0.
  - `cfg_ready` 1, `samp_pend` 0, `cfg_streak` 0.
- Reset mid-frame: `load` drops on the next edge. Any frame already started by `spi_main_x2` completes on its own, and the block ignores its `csb` edges.
- Latency: a request present in IDLE at edge N produces `load` = 1 from edge N+1.
- `parallel_in`, `power_state` and `speed_sel` are valid from edge N+1 and remain unchanged through WAIT_DONE.
- Same-cycle `sample_valid` during a sample grant: the new sample is stored as pending and does not count as a drop.
- Same-cycle `cfg_valid` handshake and config grant are impossible, because the register must be full before it can be granted.
- Back-to-back frames: at least 1 IDLE cycle between a `csb` rise and the next `load` rise.

## Test plan
- Reset, then a single sample 12'h5A5 -> `load` rises 1 cycle later, `parallel_in` = 16'h35A5, `speed_sel` = 1; `busy` falls 1 cycle after `csb` rises.
- Config 16'h04D8 with `pwr_req` = 2'b01 -> `parallel_in` = 16'h04D8, `power_state` = 01, `speed_sel` = 0, `cfg_ready` low until the grant.
- Config held continuously, sample pending -> exactly 4 config frames, then 1 sample frame, then config resumes.
- Three samples 0x001, 0x002, 0x003 during one config frame -> the next sample frame carries 16'h3003 and `drop_cnt` = 2; 300 drops -> `drop_cnt` = 255.
- `csb` tied high -> `load` high for `START_TIMEOUT` cycles, then 0; `err_timeout` = 1 and `busy` = 0; the next request is still served.
- `rst_n` pulsed low in WAIT_DONE -> all outputs take their reset values on the next edge; pending sample and config are discarded.

Source files
------------

// File: rtl/spi_dac_scheduler.sv
// Shares one SPI DAC link between the DDS sample stream (latest-wins) and the
// lossless config path; each grant becomes one frame handed to spi_main_x2.
module spi_dac_scheduler #(
  parameter logic [3:0] SAMPLE_CMD    = 4'h3,
  parameter int         CFG_BURST_MAX = 4,
  parameter int         START_TIMEOUT = 64
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [11:0] sample_data,
  input  logic        cfg_valid,
  input  logic [15:0] cfg_word,
  output logic        cfg_ready,
  input  logic [1:0]  pwr_req,
  output logic        load,
  output logic [15:0] parallel_in,
  output logic [1:0]  power_state,
  output logic        speed_sel,
  input  logic        csb,
  output logic        busy,
  output logic        err_timeout,
  output logic [7:0]  drop_cnt,
  output logic [1:0]  dbg_state
);

  localparam int SW = $clog2(CFG_BURST_MAX + 1);
  localparam int TW = $clog2(START_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [SW-1:0] cfg_streak;
  logic          samp_pend;
  logic [11:0]   samp_data;
  logic          cfg_full;
  logic [15:0]   cfg_data;
  logic          samp_win, samp_grant, cfg_grant, timeout;

  // Handshake: a config word transfers on any edge where cfg_valid && cfg_ready.
  assign cfg_ready = ~cfg_full;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // The sample overrides config only once the config streak has hit its cap.
  assign samp_win   = samp_pend && (!cfg_full || cfg_streak == SW'(CFG_BURST_MAX));
  assign samp_grant = (state == IDLE) && samp_win;
  assign cfg_grant  = (state == IDLE) && cfg_full && !samp_win;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    load      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (samp_grant || cfg_grant) state_nxt = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        timer_nxt = '0;
        state_nxt = WAIT_START;
      end
      WAIT_START: begin
        // load releases in the same cycle the link reports the frame started
        if (!csb) begin
          state_nxt = WAIT_DONE;
        end else begin
          load = 1'b1;
          if (timer == TW'(START_TIMEOUT - 2)) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
      end
      WAIT_DONE: begin
        if (csb) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      parallel_in <= 16'h0000;
      power_state <= 2'b11;
      speed_sel   <= 1'b0;
      err_timeout <= 1'b0;
      drop_cnt    <= 8'h00;
      cfg_streak  <= '0;
      samp_pend   <= 1'b0;
      samp_data   <= 12'h000;
      cfg_full    <= 1'b0;
      cfg_data    <= 16'h0000;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (timeout) err_timeout <= 1'b1;

      if (samp_grant) begin
        parallel_in <= {SAMPLE_CMD, samp_data};
        speed_sel   <= 1'b1;
        power_state <= pwr_req;
        cfg_streak  <= '0;
      end else if (cfg_grant) begin
        parallel_in <= cfg_data;
        speed_sel   <= 1'b0;
        power_state <= pwr_req;
        if (cfg_streak != SW'(CFG_BURST_MAX)) cfg_streak <= cfg_streak + SW'(1);
      end

      // A write during a sample grant refills the buffer without counting a drop.
      if (sample_valid) begin
        samp_data <= sample_data;
        samp_pend <= 1'b1;
        if (samp_pend && !samp_grant && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
      end else if (samp_grant) begin
        samp_pend <= 1'b0;
      end

      if (cfg_valid && cfg_ready) begin
        cfg_full <= 1'b1;
        cfg_data <= cfg_word;
      end else if (cfg_grant) begin
        cfg_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_dac_scheduler.sv
// Bench for spi_dac_scheduler: SPI link emulator, frame-level reference model,
// per-cycle comparison, directed scenarios and a randomized soak.
module tb_spi_dac_scheduler;

  localparam int T    = 64;
  localparam int BMAX = 4;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample_data = 12'h000;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_word = 16'h0000;
  logic        cfg_ready;
  logic [1:0]  pwr_req = 2'b00;
  logic        load;
  logic [15:0] parallel_in;
  logic [1:0]  power_state;
  logic        speed_sel;
  logic        csb = 1'b1;
  logic        busy;
  logic        err_timeout;
  logic [7:0]  drop_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  bit cfg_hold = 1'b0;
  bit csb_stuck = 1'b0;

  spi_dac_scheduler #(.SAMPLE_CMD(4'h3), .CFG_BURST_MAX(BMAX), .START_TIMEOUT(T)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .cfg_valid(cfg_valid), .cfg_word(cfg_word), .cfg_ready(cfg_ready), .pwr_req(pwr_req),
    .load(load), .parallel_in(parallel_in), .power_state(power_state), .speed_sel(speed_sel),
    .csb(csb), .busy(busy), .err_timeout(err_timeout), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SPI link emulator ----------------
  initial begin
    int d;
    int len;
    forever begin
      @(negedge sys_clk);
      if (!csb_stuck && load) begin
        d = $urandom_range(0, 3);
        repeat (d + 1) @(posedge sys_clk);
        #2 csb = 1'b0;
        len = $urandom_range(1, 5);
        repeat (len) @(posedge sys_clk);
        #2 csb = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  // A frame is described by its age in cycles since grant and whether the link
  // has acknowledged the start; expected words are queued at grant time.
  bit          m_started = 1'b0;
  bit          m_pend, m_cfg_full, m_in_frame, m_seen, m_err, m_sp;
  logic [11:0] m_samp;
  logic [15:0] m_cfg, m_pi;
  logic [1:0]  m_ps;
  int          m_streak, m_drop, m_age;
  logic [18:0] exp_q[$];
  bit          frame_log[$];

  always @(posedge sys_clk) begin
    bit sg;
    bit cg;
    bit hs;
    if (!rst_n) begin
      m_pend = 0; m_samp = '0; m_cfg_full = 0; m_cfg = '0; m_streak = 0; m_drop = 0;
      m_err = 0; m_in_frame = 0; m_seen = 0; m_age = 0;
      m_pi = 16'h0000; m_ps = 2'b11; m_sp = 0;
      exp_q.delete();
      m_started = 1;
    end else begin
      sg = 0;
      cg = 0;
      hs = cfg_valid && !m_cfg_full;
      if (m_in_frame) begin
        if (!m_seen) begin
          if (m_age >= 2 && !csb) m_seen = 1;
          else if (m_age == T) begin
            m_in_frame = 0;
            m_err = 1;
          end
        end else if (csb) begin
          m_in_frame = 0;
        end
        m_age++;
      end else begin
        if (m_pend && (!m_cfg_full || m_streak == BMAX)) sg = 1;
        else if (m_cfg_full) cg = 1;
        if (sg || cg) begin
          m_in_frame = 1;
          m_seen = 0;
          m_age = 1;
          m_ps = pwr_req;
          m_sp = sg;
          m_pi = sg ? {4'h3, m_samp} : m_cfg;
          m_streak = sg ? 0 : ((m_streak < BMAX) ? m_streak + 1 : BMAX);
          exp_q.push_back({m_ps, m_sp, m_pi});
        end
      end
      if (sample_valid) begin
        if (m_pend && !sg && m_drop < 255) m_drop++;
        m_samp = sample_data;
        m_pend = 1;
      end else if (sg) begin
        m_pend = 0;
      end
      if (hs) begin
        m_cfg_full = 1;
        m_cfg = cfg_word;
      end else if (cg) begin
        m_cfg_full = 0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  bit prev_load = 1'b0;
  always @(negedge sys_clk) begin
    logic [18:0] e;
    if (m_started) begin
      chk("load", load, m_in_frame && !m_seen && (m_age == 1 || csb));
      chk("busy", busy, m_in_frame);
      chk("cfg_ready", cfg_ready, !m_cfg_full);
      chk("err_timeout", err_timeout, m_err);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("parallel_in", parallel_in, m_pi);
      chk("power_state", power_state, m_ps);
      chk("speed_sel", speed_sel, m_sp);
      if (load && !prev_load) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_start load rose with no expected frame at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("frame_word", {power_state, speed_sel, parallel_in}, e);
        end
        frame_log.push_back(speed_sel);
      end
      prev_load = load;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    bit hs;
    hs = cfg_valid && cfg_ready;
    @(posedge sys_clk);
    #1;
    sample_valid = 1'b0;
    if (hs) begin
      if (cfg_hold) cfg_word = 16'($urandom);
      else cfg_valid = 1'b0;
    end
    @(negedge sys_clk);
  endtask

  task automatic send_sample(input logic [11:0] d);
    sample_valid = 1'b1;
    sample_data = d;
    tick();
  endtask

  task automatic send_cfg(input logic [15:0] w);
    cfg_valid = 1'b1;
    cfg_word = w;
    tick();
  endtask

  task automatic wait_load(input string name);
    int n;
    n = 0;
    while (!load && n < 200) begin
      tick();
      n++;
    end
    if (!load) begin
      checks++;
      errors++;
      $display("FAIL %s no load within 200 cycles", name);
    end
  endtask

  task automatic wait_idle();
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < 1000) begin
      tick();
      n++;
      if (!busy && !cfg_valid) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      checks++;
      errors++;
      $display("FAIL wait_idle block still busy after 1000 cycles");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_load"}, load, 0);
    chk({tag, "_pi"}, parallel_in, 16'h0000);
    chk({tag, "_ps"}, power_state, 2'b11);
    chk({tag, "_sp"}, speed_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int idx;
    @(negedge sys_clk);
    do_reset();
    chk_reset_vals("reset");

    // single sample
    send_sample(12'h5A5);
    chk("samp_not_yet", load, 0);
    tick();
    chk("samp_load", load, 1);
    chk("samp_pi", parallel_in, 16'h35A5);
    chk("samp_speed", speed_sel, 1);
    wait_idle();

    // single config
    pwr_req = 2'b01;
    send_cfg(16'h04D8);
    chk("cfg_ready_full", cfg_ready, 0);
    tick();
    chk("cfg_load", load, 1);
    chk("cfg_pi", parallel_in, 16'h04D8);
    chk("cfg_ps", power_state, 2'b01);
    chk("cfg_speed", speed_sel, 0);
    chk("cfg_ready_after_grant", cfg_ready, 1);
    wait_idle();

    // config burst cap
    send_sample(12'h111);
    wait_idle();
    frame_log.delete();
    cfg_hold = 1'b1;
    cfg_valid = 1'b1;
    cfg_word = 16'($urandom);
    wait_load("burst_first");
    send_sample(12'h777);
    n = 0;
    while (frame_log.size() < 6 && n < 400) begin
      tick();
      n++;
    end
    cfg_hold = 1'b0;
    wait_idle();
    if (frame_log.size() >= 6) begin
      idx = -1;
      for (int i = 0; i < 6; i++) if (frame_log[i] && idx < 0) idx = i;
      chk("burst_cfg_frames", idx, 4);
      chk("burst_resume", frame_log[5], 0);
    end else begin
      checks++;
      errors++;
      $display("FAIL burst_frames got %0d frames need 6", frame_log.size());
    end

    // latest-wins overwrite
    do_reset();
    send_cfg(16'h1234);
    wait_load("drop_cfg");
    send_sample(12'h001);
    send_sample(12'h002);
    send_sample(12'h003);
    chk("drop_two", drop_cnt, 2);
    wait_load("drop_samp");
    chk("drop_latest", parallel_in, 16'h3003);
    wait_idle();

    // drop counter saturation
    for (int i = 0; i < 700; i++) begin
      sample_valid = 1'b1;
      sample_data = 12'($urandom);
      tick();
    end
    wait_idle();
    chk("drop_sat", drop_cnt, 255);

    // start timeout
    csb_stuck = 1'b1;
    send_sample(12'hABC);
    wait_load("timeout");
    n = 0;
    while (load && n < 200) begin
      n++;
      tick();
    end
    chk("timeout_len", n, T);
    chk("timeout_err", err_timeout, 1);
    chk("timeout_busy", busy, 0);
    csb_stuck = 1'b0;
    send_cfg(16'hBEEF);
    wait_load("after_timeout");
    chk("after_timeout_pi", parallel_in, 16'hBEEF);
    wait_idle();

    // reset while in WAIT_DONE discards pending work
    send_cfg(16'h0F0F);
    wait_load("rst_frame");
    send_sample(12'h123);
    send_cfg(16'h5555);
    n = 0;
    while (dbg_state != 2'd3 && n < 200) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    tick();
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_quiet_busy", busy, 0);
      chk("midrst_quiet_load", load, 0);
    end

    // randomized soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        sample_valid = 1'b1;
        sample_data = 12'($urandom);
      end
      if (!cfg_valid && $urandom_range(0, 5) == 0) begin
        cfg_valid = 1'b1;
        cfg_word = 16'($urandom);
      end
      pwr_req = 2'($urandom);
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
